jtpang_palwr: RTL and testbench

- CPU-side write buffer for the Pang palette RAM.
- Queues CPU palette writes in a small FIFO and commits them to the palette RAM write port only during blanking, so colours never change mid-line.
- Serves CPU palette reads in program order: a read first drains all queued writes, then reads the RAM.
- Sits between the CPU bus decoder and the palette RAM port that the colour mixer reads from.

---
 rtl/jtpang_palwr.sv | 205 ++++++++++++++++++++
 tb/tb_jtpang_palwr.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpang_palwr.sv
// Palette write buffer for Pang.
// CPU palette writes are queued in a small FIFO and committed to the
// palette RAM only during blanking, so colours never change mid-line.
// CPU reads drain the queue first, then read the RAM, which keeps reads
// and writes in program order. cpu_wait stalls the CPU while the FIFO
// overflows into the pending slot and while a read is being served.

module jtpang_palwr #(
    parameter int AW         = 3,
    parameter int BLANK_ONLY = 1
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        LHBL,
    input  logic        LVBL,
    input  logic        pal_cs,
    input  logic        wr_n,
    input  logic        rd_n,
    input  logic        pal_bank,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  pal_dout,
    output logic        cpu_wait,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_q
);

    localparam int DEPTH = 1 << AW;
    // One FIFO entry: {ram address, data}
    localparam int EW    = 20;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_RADDR = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    // CPU strobes and their edge detectors
    logic        wr_ev, rd_ev;
    logic        wr_ev_l, rd_ev_l;
    logic        wr_edge, rd_edge;

    // RAM address formed from the CPU address at capture time
    logic [11:0] cpu_ram_addr;

    // FIFO storage and pointers (AW bits plus a wrap bit)
    logic [EW-1:0] fifo_mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty;
    logic [EW-1:0] head;

    // One-entry overflow slot used while the FIFO is full
    logic          pend_valid;
    logic [EW-1:0] pend_entry;
    logic          pend_nx;

    // Push / pop control
    logic          commit_ok;
    logic          pop;
    logic          can_push;
    logic          push_pend;
    logic          push_edge;
    logic          edge_to_pend;
    logic          push;
    logic [EW-1:0] push_entry;

    // Read FSM
    logic [1:0]  state, state_nx;
    logic [11:0] rd_addr;
    logic        drained;

    assign wr_ev   = pal_cs & ~wr_n;
    assign rd_ev   = pal_cs & ~rd_n & wr_n;
    assign wr_edge = wr_ev & ~wr_ev_l;
    assign rd_edge = rd_ev & ~rd_ev_l;

    assign cpu_ram_addr = {cpu_addr[0], pal_bank, cpu_addr[10:1]};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = fifo_mem[rd_ptr[AW-1:0]];

    // Commits are only allowed while the beam is blanked, unless the
    // instance is configured to commit at any time.
    assign commit_ok = (BLANK_ONLY != 0) ? (~LHBL | ~LVBL) : 1'b1;

    // The RADDR cycle owns ram_addr, so the commit path stands aside.
    // The FIFO is empty by then, so no entry is held back.
    assign pop = ~empty & commit_ok & (state != ST_RADDR);

    // A pop in the same cycle frees a slot for a push even when full
    assign can_push = ~full | pop;

    // The pending write is older than any new edge, so it goes first.
    // A new edge while the pending slot is stuck can only happen if the
    // CPU ignores cpu_wait; it then replaces the pending write.
    assign push_pend    = pend_valid & can_push;
    assign push_edge    = wr_edge & ~pend_valid & can_push;
    assign edge_to_pend = wr_edge & ~push_edge;
    assign push         = push_pend | push_edge;
    assign push_entry   = push_pend ? pend_entry : {cpu_ram_addr, cpu_dout};
    assign pend_nx      = edge_to_pend | (pend_valid & ~push_pend);

    assign drained = empty & ~pend_valid;

    // Strobe edge detectors: a held strobe counts as a single access
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // always_ff samples the same pre-edge values.
        if (rst) begin
            wr_ev_l <= 1'b0;
            rd_ev_l <= 1'b0;
        end else begin
            wr_ev_l <= wr_ev;
            rd_ev_l <= rd_ev;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; the pointers alone define
        // which entries are valid, and leaving it out keeps it a plain RAM.
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    // FIFO pointers and the overflow slot
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pend_valid <= 1'b0;
            pend_entry <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            pend_valid <= pend_nx;
            if (edge_to_pend) begin
                pend_entry <= {cpu_ram_addr, cpu_dout};
            end
        end
    end

    // Read FSM next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nx
        // unassigned, which would infer a latch.
        state_nx = state;
        case (state)
            ST_IDLE:  if (rd_edge) state_nx = ST_DRAIN;
            ST_DRAIN: if (drained) state_nx = ST_RADDR;
            ST_RADDR: state_nx = ST_RDATA;
            ST_RDATA: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Read FSM state, latched read address and CPU read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rd_addr  <= '0;
            pal_dout <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && rd_edge) begin
                rd_addr <= cpu_ram_addr;
            end
            // ram_q answers the address driven during RADDR
            if (state == ST_RDATA) begin
                pal_dout <= ram_q;
            end
        end
    end

    // CPU stall: overflow slot occupied or a read in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_wait <= 1'b0;
        end else begin
            cpu_wait <= pend_nx | (state_nx != ST_IDLE);
        end
    end

    // Palette RAM port: commits from the FIFO head, or the read address
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_we <= pop;
            if (pop) begin
                ram_addr <= head[EW-1:8];
                ram_din  <= head[7:0];
            end else if (state == ST_DRAIN && drained) begin
                ram_addr <= rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_jtpang_palwr.sv
// Directed bench for jtpang_palwr: a table of single writes with their
// expected RAM address/data, plus hand-written sequences for queueing,
// overflow, read draining, simultaneous push/pop and mid-run reset.

module tb_jtpang_palwr;

    logic        clk = 1'b0;
    logic        rst;
    logic        LHBL, LVBL;
    logic        pal_cs, wr_n, rd_n, pal_bank;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  pal_dout;
    logic        cpu_wait;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_q;

    int n_vec = 0;
    int n_err = 0;
    logic wait_seen = 1'b0;

    jtpang_palwr #(.AW(3), .BLANK_ONLY(1)) dut (
        .rst      (rst),
        .clk      (clk),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .pal_cs   (pal_cs),
        .wr_n     (wr_n),
        .rd_n     (rd_n),
        .pal_bank (pal_bank),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .pal_dout (pal_dout),
        .cpu_wait (cpu_wait),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_q    (ram_q)
    );

    always #5 clk = ~clk;

    // Palette RAM model: synchronous read, q valid 1 clk after address
    logic [7:0] mem [4096];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    // Commit log: every ram_we cycle with its address, data and cycle
    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
        int          cyc;
    } commit_t;
    commit_t log_q[$];
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) log_q.push_back('{ram_addr, ram_din, cyc});
    end

    typedef struct {
        logic        lhbl;
        logic        lvbl;
        logic        bank;
        logic [10:0] addr;
        logic [7:0]  data;
        logic [11:0] exp_addr;
        logic [7:0]  exp_data;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (cpu_wait) wait_seen = 1'b1;
    endtask

    task automatic cpu_write(input logic bank, input logic [10:0] addr,
                             input logic [7:0] data, input int hold);
        pal_bank = bank;
        cpu_addr = addr;
        cpu_dout = data;
        rd_n     = 1'b1;
        pal_cs   = 1'b1;
        wr_n     = 1'b0;
        repeat (hold) step();
        pal_cs = 1'b0;
        wr_n   = 1'b1;
        step();
    endtask

    // Compare log entry idx against an expected address/data pair
    task automatic check_commit(input string name, input int idx,
                                input logic [11:0] ea, input logic [7:0] ed);
        if (idx < log_q.size()) begin
            check({name, "_addr"}, 32'(log_q[idx].a), 32'(ea));
            check({name, "_data"}, 32'(log_q[idx].d), 32'(ed));
        end else begin
            check({name, "_present"}, log_q.size(), idx + 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int t;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 11'h005, 8'h3C, 12'hC02, 8'h3C};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 11'h000, 8'h01, 12'h000, 8'h01};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 11'h7FF, 8'hA5, 12'hBFF, 8'hA5};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 11'h7FE, 8'hFF, 12'h7FF, 8'hFF};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 11'h401, 8'h5A, 12'hA00, 8'h5A};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 11'h123, 8'h77, 12'hC91, 8'h77};

        rst = 1'b1; LHBL = 1'b1; LVBL = 1'b1;
        pal_cs = 1'b0; wr_n = 1'b1; rd_n = 1'b1; pal_bank = 1'b0;
        cpu_addr = '0; cpu_dout = '0;
        repeat (3) step();
        check("rst_pal_dout", 32'(pal_dout), 0);
        check("rst_cpu_wait", 32'(cpu_wait), 0);
        check("rst_ram_we",   32'(ram_we),   0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_din",  32'(ram_din),  0);
        rst = 1'b0;
        step();

        // Single writes during blank, strobe held 10 clks: one commit each
        for (int i = 0; i < 6; i++) begin
            LHBL = vecs[i].lhbl;
            LVBL = vecs[i].lvbl;
            n0 = log_q.size();
            cpu_write(vecs[i].bank, vecs[i].addr, vecs[i].data, 10);
            repeat (3) step();
            check($sformatf("vec%0d_count", i), log_q.size() - n0, 1);
            check_commit($sformatf("vec%0d", i), n0, vecs[i].exp_addr, vecs[i].exp_data);
        end
        LHBL = 1'b1; LVBL = 1'b1;
        step();

        // Three writes held back in active video, then committed back to back
        n0 = log_q.size();
        wait_seen = 1'b0;
        cpu_write(1'b0, 11'h010, 8'h21, 2);
        cpu_write(1'b0, 11'h011, 8'h22, 2);
        cpu_write(1'b0, 11'h012, 8'h23, 2);
        repeat (3) step();
        check("active_no_commit", log_q.size() - n0, 0);
        LHBL = 1'b0;
        repeat (6) step();
        check("blank3_count", log_q.size() - n0, 3);
        check_commit("blank3_0", n0,     12'h008, 8'h21);
        check_commit("blank3_1", n0 + 1, 12'h808, 8'h22);
        check_commit("blank3_2", n0 + 2, 12'h009, 8'h23);
        if (log_q.size() >= n0 + 3) begin
            check("blank3_b2b_a", log_q[n0 + 1].cyc - log_q[n0].cyc, 1);
            check("blank3_b2b_b", log_q[n0 + 2].cyc - log_q[n0 + 1].cyc, 1);
        end
        check("blank3_no_wait", 32'(wait_seen), 0);
        LHBL = 1'b1;
        step();

        // Nine writes into an 8-deep FIFO: the ninth stalls the CPU
        n0 = log_q.size();
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check("ovf_wait_before_9th", 32'(cpu_wait), 0);
            cpu_write(1'b0, 11'(2 * (16 + i)), 8'(8'h80 + i), 2);
        end
        check("ovf_wait_on_9th", 32'(cpu_wait), 1);
        check("ovf_no_commit", log_q.size() - n0, 0);
        LHBL = 1'b0;
        step();
        check("ovf_wait_fall", 32'(cpu_wait), 0);
        check("ovf_first_we", 32'(ram_we), 1);
        repeat (12) step();
        check("ovf_count", log_q.size() - n0, 9);
        for (int k = 0; k < 9; k++) begin
            check_commit($sformatf("ovf_%0d", k), n0 + k, 12'(16 + k), 8'(8'h80 + k));
        end
        LHBL = 1'b1;
        step();

        // Read with two queued writes: drains at blank, then reads the RAM
        LHBL = 1'b0;
        cpu_write(1'b1, 11'h005, 8'h00, 2);
        repeat (3) step();
        LHBL = 1'b1;
        step();
        n0 = log_q.size();
        cpu_write(1'b1, 11'h005, 8'h11, 2);
        cpu_write(1'b1, 11'h005, 8'h3C, 2);
        pal_bank = 1'b1; cpu_addr = 11'h005; wr_n = 1'b1; rd_n = 1'b0; pal_cs = 1'b1;
        repeat (4) step();
        check("rd_stall", 32'(cpu_wait), 1);
        check("rd_stall_no_commit", log_q.size() - n0, 0);
        check("rd_dout_before", 32'(pal_dout), 0);
        LHBL = 1'b0;
        t = 0;
        while (cpu_wait && t < 30) begin
            step();
            t++;
        end
        check("rd_wait_released", 32'(t < 30), 1);
        check("rd_dout", 32'(pal_dout), 32'h3C);
        check("rd_drain_count", log_q.size() - n0, 2);
        check_commit("rd_drain_0", n0,     12'hC02, 8'h11);
        check_commit("rd_drain_1", n0 + 1, 12'hC02, 8'h3C);
        pal_cs = 1'b0; rd_n = 1'b1;
        LHBL = 1'b1;
        repeat (3) step();
        check("rd_dout_hold", 32'(pal_dout), 32'h3C);
        check("rd_wait_low", 32'(cpu_wait), 0);

        // Push and pop in the same blank cycle with four entries queued
        n0 = log_q.size();
        for (int i = 0; i < 4; i++) begin
            cpu_write(1'b0, 11'(2 * (40 + i)), 8'(8'hC0 + i), 2);
        end
        pal_bank = 1'b0; cpu_addr = 11'(2 * 44); cpu_dout = 8'hC4;
        LHBL = 1'b0; pal_cs = 1'b1; wr_n = 1'b0;
        step();
        LHBL = 1'b1;
        repeat (2) step();
        pal_cs = 1'b0; wr_n = 1'b1;
        step();
        check("pp_one_pop", log_q.size() - n0, 1);
        for (int i = 5; i < 9; i++) begin
            cpu_write(1'b0, 11'(2 * (40 + i)), 8'(8'hC0 + i), 2);
        end
        check("pp_full_no_wait", 32'(cpu_wait), 0);
        cpu_write(1'b0, 11'(2 * 49), 8'hC9, 2);
        check("pp_pending_wait", 32'(cpu_wait), 1);
        LHBL = 1'b0;
        repeat (14) step();
        check("pp_count", log_q.size() - n0, 10);
        for (int k = 0; k < 10; k++) begin
            check_commit($sformatf("pp_%0d", k), n0 + k, 12'(40 + k), 8'(8'hC0 + k));
        end
        check("pp_wait_low", 32'(cpu_wait), 0);
        LHBL = 1'b1;
        step();

        // Reset with five entries queued and a read stalled
        n0 = log_q.size();
        for (int i = 0; i < 5; i++) begin
            cpu_write(1'b0, 11'(2 * (60 + i)), 8'(8'hE0 + i), 2);
        end
        pal_bank = 1'b0; cpu_addr = 11'h100; wr_n = 1'b1; rd_n = 1'b0; pal_cs = 1'b1;
        repeat (3) step();
        check("rst_mid_wait_before", 32'(cpu_wait), 1);
        rst = 1'b1;
        LHBL = 1'b0;
        step();
        check("rst_mid_we", 32'(ram_we), 0);
        check("rst_mid_wait", 32'(cpu_wait), 0);
        pal_cs = 1'b0; rd_n = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        check("rst_mid_no_commit", log_q.size() - n0, 0);
        check("rst_mid_wait_after", 32'(cpu_wait), 0);
        LHBL = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
